mic_sample_fifo: RTL and testbench
==================================

# mic_sample_fifo

Downstream consumer of the I2S microphone receiver: detects each new 16-bit sample (rising edge of the receiver's `dataflag`), captures it into a circular sample memory, and presents buffered samples to the storage/processing side through a valid/ready stream. Absorbs the 18.75 kS/s bursty arrival against a consumer that may stall. Reports fill level and latches overflow.

## Interface
- `DEPTH`, 256: sample-memory entries; power of two, ≥ 4.
- `SAMPLE_W`, 16: sample width; matches receiver `data`.

- `clk` in 1: 24 MHz system clock, same clock as the I2S receiver.
- `rst` in 1: asynchronous, active-low reset.
- `sample_in` in SAMPLE_W: receiver `data`; two's complement, stable while `sample_flag` high.
- `sample_flag` in 1: receiver `dataflag`; high ≈320 clk per sample.
- `out_data` out SAMPLE_W: head sample.
- `out_valid` out 1: `out_data` holds a sample.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `level` out log2(DEPTH)+2: samples held (memory + output register), 0..DEPTH+1.
- `overflow` out 1: sticky; a sample was dropped.
- `ovf_clr` in 1: one-cycle pulse clears `overflow`.

## Operation
- Reset values: `out_data` 0, `out_valid` 0, `level` 0, `overflow` 0; pointers 0; `flag_d` 0. Memory contents not cleared.
- Edge detect: `flag_d` registers `sample_flag`. `push` = `sample_flag & ~flag_d`. One push per flag high period; flag held high never re-pushes.
- Pointers: `wr_ptr`, `rd_ptr` are log2(DEPTH)+1 bits; natural wrap. Empty = equal; full = MSBs differ, lower bits equal.
- Push: if memory not full, `mem[wr_ptr] <= sample_in`, `wr_ptr++`. If full, the sample is dropped and `overflow` set. Fullness is the registered state; a same-cycle load from memory does not free space for that push.
- Output register: loads when memory not empty and (`~out_valid` or `out_valid & out_ready`): `out_data <= mem[rd_ptr]` (synchronous read), `rd_ptr++`, `out_valid <= 1`. If `out_valid & out_ready` and memory empty: `out_valid <= 0`, `out_data` holds its last value.
- Push into empty memory and load in same cycle: the load sees the pre-edge empty state and does not occur; the load happens next cycle.
- `level` = memory count + `out_valid`, updated each edge. Push and pop in the same cycle leave it unchanged.
- `overflow`: set on a dropped push; cleared by `ovf_clr`; set wins when both occur in the same cycle.
- Reset mid-operation: everything returns to reset values immediately (async). Buffered samples are lost.

## Timing
- First `sample_flag` high cycle C: push at end of C. Load at end of C+1. `out_valid` visible in C+2 (2-cycle latency when empty).
- Throughput: with the memory non-empty and `out_ready` held high, one sample per cycle.
- `out_data` is stable while `out_valid & ~out_ready`.
- `level` and `overflow` are registered and reflect state after the edge.

## Structure
- Shared package `mic_pkg`: `SAMPLE_W`, default `DEPTH`, `sample_t` typedef. Reused by the receiver and the storage controller.
- Sub-module `sample_ram`: simple dual-port RAM (one write port, one synchronous read port, no reset) so it infers EBR/SPRAM. Pointers, edge detect, output register and flags live in `mic_sample_fifo`.

## Test plan
- Reset, then one flag pulse with `sample_in`=16'h8001, `out_ready`=1. Required: `out_valid` high in C+2 for exactly one cycle, `out_data`=16'h8001, `level` 1→0.
- `sample_flag` held high 320 cycles with `sample_in` changing. Required: exactly one push, capturing the value present on the first high cycle.
- `out_ready`=0, push DEPTH+1 samples 0..DEPTH. Required: `level`=DEPTH+1, `overflow`=0. Next push (value 16'hDEAD) dropped, `overflow`=1. Draining yields 0..DEPTH in order, back-to-back.
- Push while `out_valid & out_ready` with memory empty. Required: `out_valid` drops for one cycle, then the new sample appears; no duplicate or lost sample.
- `ovf_clr` asserted in the same cycle as a dropped push. Required: `overflow` stays 1; a later lone `ovf_clr` clears it.
- Assert `rst` with 10 samples buffered. Required: `out_valid`, `level`, `overflow` go to 0 asynchronously. After release, the first new sample is the first output.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared definitions for the microphone capture path: sample format and the
// default sample-buffer depth. Used by the receiver, this FIFO and the
// storage controller so every block agrees on the sample width.
package mic_pkg;

   // Width of one PCM sample produced by the I2S receiver.
   localparam int SAMPLE_W = 16;

   // Default number of sample-memory entries (power of two, at least 4).
   localparam int DEPTH_DEFAULT = 256;

   // One two's-complement microphone sample.
   typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : mic_pkg

// File: rtl/mic_sample_fifo_if.sv
// Valid/ready sample stream from the FIFO to the storage/processing side.
// The master owns data and valid; the slave owns ready.
interface mic_sample_fifo_if
   import mic_pkg::*;
   ();

   sample_t out_data;
   logic    out_valid;
   logic    out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface : mic_sample_fifo_if

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port and one registered read
// port sharing the system clock. No reset, so it maps onto block RAM.
module sample_ram
   import mic_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  sample_t       wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output sample_t       rd_data
);

   sample_t mem [DEPTH];
   sample_t rd_data_q;

   // Write port and enabled synchronous read; the read register holds its
   // value whenever rd_en is low.
   // NOTE: the array and its read register are deliberately left without a
   // reset; adding one would stop the memory from mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule : sample_ram

// File: rtl/mic_sample_fifo.sv
// Captures each new receiver sample (rising edge of its data flag) into a
// circular buffer and streams buffered samples out through valid/ready.
// Reports the number of samples held and latches a sticky overflow flag.
module mic_sample_fifo
   import mic_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  sample_t                  sample_in,
   input  logic                     sample_flag,
   mic_sample_fifo_if.master        out_if,
   output logic [$clog2(DEPTH)+1:0] level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;   // pointer width: one extra wrap bit
   localparam int LW = AW + 2;   // level counts up to DEPTH + 1

   // Registered state and next-state values.
   logic          flag_q;
   logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
   logic          out_valid_q, out_valid_d;
   logic          loaded_q,    loaded_d;
   logic [LW-1:0] level_q,     level_d;
   logic          overflow_q,  overflow_d;

   // Per-cycle control decisions.
   logic    push;
   logic    mem_empty;
   logic    mem_full;
   logic    wr_en;
   logic    drop;
   logic    accept;
   logic    load;
   sample_t ram_rd_data;

   // One push per flag high period, regardless of how long the flag stays up.
   assign push = sample_flag & ~flag_q;

   // Empty/full come from registered pointers only, so a load in the same
   // cycle neither frees space for a push nor sees a same-cycle push.
   assign mem_empty = (wr_ptr_q == rd_ptr_q);
   assign mem_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign wr_en  = push & ~mem_full;
   assign drop   = push &  mem_full;
   assign accept = out_valid_q & out_if.out_ready;
   assign load   = ~mem_empty & (~out_valid_q | out_if.out_ready);

   sample_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (sample_in),
      .rd_en   (load),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (ram_rd_data)
   );

   // Next-state for pointers, output-register status, level and overflow.
   // NOTE: every signal gets its default first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      loaded_d    = loaded_q;
      overflow_d  = overflow_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (load) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         out_valid_d = 1'b1;
         loaded_d    = 1'b1;
      end else if (accept) begin
         out_valid_d = 1'b0;
      end

      // Samples held change only by entering memory or leaving to the
      // consumer; moving memory -> output register keeps the total.
      level_d = level_q + LW'(wr_en) - LW'(accept);

      // A dropped sample takes priority over a clear in the same cycle.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         loaded_q    <= 1'b0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         flag_q      <= sample_flag;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         loaded_q    <= loaded_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
      end
   end

   // The RAM read register is the output data register. It has no reset, so
   // out_data is forced to zero until the first load after reset; from then
   // on it holds the last loaded sample.
   assign out_if.out_data  = loaded_q ? ram_rd_data : '0;
   assign out_if.out_valid = out_valid_q;
   assign level            = level_q;
   assign overflow         = overflow_q;

endmodule : mic_sample_fifo

// File: tb/tb_mic_sample_fifo.sv
// Directed testbench for mic_sample_fifo: a per-cycle vector table for the
// basic stream behaviour, then hand-written sequences for held flags,
// overflow, clear priority and asynchronous reset.
module tb_mic_sample_fifo;
   import mic_pkg::*;

   localparam int DEPTH = 256;
   localparam int LW    = $clog2(DEPTH) + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   sample_t       sample_in = '0;
   logic          sample_flag = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [LW-1:0] level;
   logic          overflow;

   mic_sample_fifo_if bus ();

   mic_sample_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_in   (sample_in),
      .sample_flag (sample_flag),
      .out_if      (bus),
      .level       (level),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic    flag;
      sample_t din;
      logic    rdy;
      logic    clr;
      logic    exp_valid;
      sample_t exp_data;
      int      exp_level;
      logic    exp_ovf;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One flag pulse (one cycle high, one cycle low) carrying value v.
   task automatic pulse(input sample_t v, input logic clr);
      sample_flag = 1'b1;
      sample_in   = v;
      ovf_clr     = clr;
      step();
      sample_flag = 1'b0;
      ovf_clr     = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Expected state after the edge that consumes each row's inputs.
      //           flag din       rdy  clr  valid data      lvl ovf
      vecs[0]  = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b0};
      vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h8001, 1, 1'b0};
      vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8001, 0, 1'b0};
      vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8001, 0, 1'b0};
      vecs[4]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h8001, 1, 1'b0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 1, 1'b0};
      vecs[6]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h1111, 1, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 1, 1'b0};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h2222, 0, 1'b0};
      vecs[9]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h2222, 1, 1'b0};
      vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3333, 1, 1'b0};
      vecs[11] = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 16'h3333, 2, 1'b0};
      vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3333, 2, 1'b0};
      vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4444, 1, 1'b0};
      vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4444, 0, 1'b0};

      bus.out_ready = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset valid", 32'(bus.out_valid), 32'd0);
      check("reset data",  32'(bus.out_data),  32'd0);
      check("reset level", 32'(level),         32'd0);
      check("reset ovf",   32'(overflow),      32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Table: single pulse latency, push during pop of the last sample,
      // and a stall with two samples held.
      for (int i = 0; i < 15; i++) begin
         sample_flag   = vecs[i].flag;
         sample_in     = vecs[i].din;
         bus.out_ready = vecs[i].rdy;
         ovf_clr       = vecs[i].clr;
         step();
         check($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d data", i),  32'(bus.out_data),  32'(vecs[i].exp_data));
         check($sformatf("vec%0d level", i), 32'(level),         32'(vecs[i].exp_level));
         check($sformatf("vec%0d ovf", i),   32'(overflow),      32'(vecs[i].exp_ovf));
      end
      sample_flag   = 1'b0;
      bus.out_ready = 1'b0;
      step();

      // Flag held high 320 cycles while the data keeps changing.
      sample_flag = 1'b1;
      sample_in   = 16'h5A5A;
      step();
      check("held first level", 32'(level), 32'd1);
      for (int k = 1; k < 320; k++) begin
         sample_in = sample_t'(k * 7);
         step();
      end
      sample_flag = 1'b0;
      sample_in   = '0;
      step();
      check("held level", 32'(level), 32'd1);
      check("held out", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, 16'h5A5A});
      bus.out_ready = 1'b1;
      step();
      check("held drained valid", 32'(bus.out_valid), 32'd0);
      check("held drained level", 32'(level), 32'd0);
      bus.out_ready = 1'b0;

      // Fill to DEPTH+1 with the consumer stalled.
      for (int i = 0; i <= DEPTH; i++) begin
         pulse(sample_t'(i), 1'b0);
      end
      check("full level", 32'(level), 32'(DEPTH + 1));
      check("full ovf", 32'(overflow), 32'd0);
      pulse(16'hDEAD, 1'b0);
      check("drop ovf", 32'(overflow), 32'd1);
      check("drop level", 32'(level), 32'(DEPTH + 1));

      // Clear in the same cycle as another drop: set wins.
      sample_flag = 1'b1;
      sample_in   = 16'hBEEF;
      ovf_clr     = 1'b1;
      step();
      check("clr+drop ovf", 32'(overflow), 32'd1);
      sample_flag = 1'b0;
      ovf_clr     = 1'b0;
      step();
      check("after clr+drop ovf", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("lone clr ovf", 32'(overflow), 32'd0);

      // Drain: samples 0..DEPTH in order, one per cycle, no gaps.
      bus.out_ready = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         check($sformatf("drain %0d", i), {15'd0, bus.out_valid, bus.out_data},
               {15'd0, 1'b1, sample_t'(i)});
         step();
      end
      check("drained valid", 32'(bus.out_valid), 32'd0);
      check("drained level", 32'(level), 32'd0);
      bus.out_ready = 1'b0;

      // Asynchronous reset with 10 samples buffered.
      for (int i = 0; i < 10; i++) begin
         pulse(sample_t'(16'h0100 + i), 1'b0);
      end
      check("pre-reset level", 32'(level), 32'd10);
      #3 rst = 1'b0;
      #1;
      check("async rst valid", 32'(bus.out_valid), 32'd0);
      check("async rst level", 32'(level), 32'd0);
      check("async rst data",  32'(bus.out_data), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Asynchronous reset clears a set overflow flag.
      for (int i = 0; i < DEPTH + 2; i++) begin
         pulse(sample_t'(i), 1'b0);
      end
      check("refill ovf", 32'(overflow), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("async rst ovf", 32'(overflow), 32'd0);
      check("async rst level2", 32'(level), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // First sample after reset is the first output.
      bus.out_ready = 1'b1;
      pulse(16'h7777, 1'b0);
      check("post-reset out", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, 16'h7777});
      step();
      check("post-reset valid", 32'(bus.out_valid), 32'd0);
      check("post-reset level", 32'(level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mic_sample_fifo
